oclib_credit_receiver: RTL and testbench

- Receive end of a credit-flow-controlled link; presents received words as a standard ready/valid stream.
- Upstream transmitter sends a word only while it holds a credit. This block buffers words in a Depth-entry FIFO and returns one credit per freed entry.
- Used where a long or retimed path makes combinational ready backpressure impractical. The sender side consumes our creditOut pulses.

---
 rtl/oclib_pkg.sv | 8 +
 rtl/oclib_credit_return.sv | 41 ++++
 rtl/oclib_credit_receiver.sv | 93 +++++++++
 tb/tb_oclib_credit_receiver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared definitions for the oclib link blocks.
package oclib_pkg;

  // Credit link: one credit admits exactly one word, and each returned credit
  // is a single-cycle creditOut pulse.
  localparam int CreditPerWord = 1;

endpackage

// File: rtl/oclib_credit_return.sv
// Credit return: counts freed FIFO entries and replays them to the sender as
// one-cycle creditOut pulses; the initial grant falls out of the reset value.
module oclib_credit_return
  import oclib_pkg::*;
#(
  parameter int Depth      = 8,
  parameter int CountWidth = $clog2(Depth + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic pop,
  output logic creditOut
);

  logic [CountWidth-1:0] creditPending_q, creditPending_d;
  logic                  creditOut_q;

  always_comb begin
    creditPending_d = creditPending_q;
    if (pop) begin
      creditPending_d = creditPending_d + CountWidth'(CreditPerWord);
    end
    if (creditOut_q) begin
      creditPending_d = creditPending_d - CountWidth'(CreditPerWord);
    end
  end

  // Starting from Depth pending credits yields Depth pulses after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      creditPending_q <= CountWidth'(Depth);
      creditOut_q     <= 1'b0;
    end else begin
      creditPending_q <= creditPending_d;
      creditOut_q     <= (creditPending_d != '0);
    end
  end

  assign creditOut = creditOut_q;

endmodule

// File: rtl/oclib_credit_receiver.sv
// Receive end of a credit-flow-controlled link: buffers credit-gated words in a
// Depth-entry first-word-fall-through FIFO and returns a credit per freed entry.
module oclib_credit_receiver
  import oclib_pkg::*;
#(
  parameter int Width      = 32,
  parameter int Depth      = 8,
  parameter int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [Width-1:0]      inData,
  input  logic                  inValid,
  output logic                  creditOut,
  output logic [Width-1:0]      outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [CountWidth-1:0] count,
  output logic                  overflowError
);

  localparam int PtrWidth = $clog2(Depth);

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wrPtr_q, rdPtr_q;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  overflow_q;
  logic                  full, push, pop;

  function automatic logic [PtrWidth-1:0] ptrInc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full     = (count_q == CountWidth'(Depth));
  assign outValid = (count_q != '0);
  assign pop      = outValid && outReady;
  // A word arriving at full is still legal when a pop frees the slot this cycle.
  assign push     = inValid && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= ptrInc(wrPtr_q);
      end
      if (pop) begin
        rdPtr_q <= ptrInc(rdPtr_q);
      end
      count_q <= count_d;
      if (inValid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= inData;
    end
  end

  assign outData       = mem_q[rdPtr_q];
  assign count         = count_q;
  assign overflowError = overflow_q;

  oclib_credit_return #(
    .Depth      (Depth),
    .CountWidth (CountWidth)
  ) u_credit_return (
    .clock     (clock),
    .reset     (reset),
    .pop       (pop),
    .creditOut (creditOut)
  );

endmodule

// File: tb/tb_oclib_credit_receiver.sv
// Directed and randomised bench for oclib_credit_receiver at Depth = 4.
module tb_oclib_credit_receiver;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  inData = '0;
  logic          inValid = 1'b0;
  logic          outReady = 1'b0;
  logic          creditOut;
  logic [W-1:0]  outData;
  logic          outValid;
  logic [CW-1:0] count;
  logic          overflowError;

  oclib_credit_receiver #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inData        (inData),
    .inValid       (inValid),
    .creditOut     (creditOut),
    .outData       (outData),
    .outValid      (outValid),
    .outReady      (outReady),
    .count         (count),
    .overflowError (overflowError)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          m_count, m_pend, credits, pulses;
  logic        m_cout, m_ovf;
  logic [31:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pend  = D;
    m_cout  = 1'b0;
    credits = 0;
    m_ovf   = 1'b0;
    q.delete();
  endtask

  // One clock: drive inputs, step past the edge, update the model, compare.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic rdy);
    logic m_pop, m_push, pre_cout;
    inValid  = iv;
    inData   = d;
    outReady = rdy;
    #1;
    m_pop    = (m_count != 0) && rdy;
    m_push   = iv && ((m_count < D) || m_pop);
    pre_cout = creditOut;
    @(posedge clock);
    #1;
    if (pre_cout) credits++;
    if (m_push) begin
      credits--;
      q.push_back(d);
    end else if (iv) begin
      m_ovf = 1'b1;
    end
    if (m_pop) void'(q.pop_front());
    m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    m_pend  = m_pend + (m_pop ? 1 : 0) - (m_cout ? 1 : 0);
    m_cout  = (m_pend != 0);
    pulses += int'(creditOut);
    check("count", 32'(count), 32'(m_count));
    check("outValid", 32'(outValid), 32'(m_count != 0));
    check("creditOut", 32'(creditOut), 32'(m_cout));
    check("overflowError", 32'(overflowError), 32'(m_ovf));
    if (q.size() != 0) check("outData", outData, q[0]);
    check("credit_sum", 32'(credits + int'(count) + m_pend), 32'(D));
  endtask

  task automatic fill4(input logic [31:0] v0, v1, v2, v3);
    logic [31:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) cycle(1'b1, v[i], 1'b0);
  endtask

  task automatic drain4(input logic [31:0] v0, v1, v2, v3);
    logic [31:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      check("drain_data", outData, v[i]);
      cycle(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_async_outValid", 32'(outValid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_overflow", 32'(overflowError), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    check("rst_creditOut", 32'(creditOut), 32'h0);
    reset = 1'b1;
    pulses = 0;
    repeat (7) cycle(1'b0, 32'h0, 1'b0);
    check("grant_pulses", 32'(pulses), 32'(D));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic iv;
    model_reset();
    #3;
    check("reset_outValid", 32'(outValid), 32'h0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_creditOut", 32'(creditOut), 32'h0);
    check("reset_overflow", 32'(overflowError), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    pulses = 0;
    repeat (8) cycle(1'b0, 32'h0, 1'b0);
    check("init_grant_pulses", 32'(pulses), 32'd4);

    pulses = 0;
    fill4(32'h11, 32'h22, 32'h33, 32'h44);
    check("fill_count", 32'(count), 32'd4);
    check("fill_outValid", 32'(outValid), 32'd1);
    check("fill_head", outData, 32'h11);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    check("held_head", outData, 32'h11);
    check("no_extra_credit", 32'(pulses), 32'd0);

    pulses = 0;
    drain4(32'h11, 32'h22, 32'h33, 32'h44);
    check("drain_pulses", 32'(pulses), 32'd4);
    cycle(1'b0, 32'h0, 1'b0);
    check("drain_count", 32'(count), 32'd0);

    fill4(32'h11, 32'h22, 32'h33, 32'h44);
    cycle(1'b1, 32'h55, 1'b1);
    check("pushpop_count", 32'(count), 32'd4);
    check("pushpop_overflow", 32'(overflowError), 32'd0);
    drain4(32'h22, 32'h33, 32'h44, 32'h55);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);

    fill4(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    cycle(1'b1, 32'h66, 1'b0);
    check("ovf_set", 32'(overflowError), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    repeat (2) cycle(1'b0, 32'h0, 1'b0);
    check("ovf_sticky", 32'(overflowError), 32'd1);
    drain4(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    cycle(1'b0, 32'h0, 1'b1);
    check("ovf_dropped_empty", 32'(outValid), 32'd0);

    do_reset();

    for (int i = 0; i < 10000; i++) begin
      iv = (credits > 0) && ($urandom_range(0, 3) != 0);
      cycle(iv, $urandom, 1'($urandom_range(0, 1)));
    end
    cycle(credits > 0, 32'hBEEF0001, 1'b0);
    cycle(credits > 0, 32'hBEEF0002, 1'b0);
    check("preburst_outValid", 32'(outValid), 32'd1);
    do_reset();
    check("postreset_overflow", 32'(overflowError), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
